// File: rtl/mmu_ctx.sv
// rtl/mmu_ctx.sv - multi-context page-map MMU with R/D tracking and flush engine (optional feature macro: MMU_DIRTY_EN)
module mmu_ctx #(
    parameter int RV   = 16,
    parameter int VA   = RV,
    parameter int PA   = RV,
    parameter int NMMU = 8,
    parameter int NCTX = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      is_pc,
    input  logic                      is_read,
    input  logic                      is_write,
    input  logic                      mmu_enable,
    input  logic                      mmu_d_proxy,
    input  logic                      supmode,
    input  logic [$clog2(NCTX)-1:0]   ctx,
    input  logic [VA-1:RV/16]         pcv,
    input  logic [VA-1:RV/16]         addrv,
    output logic [PA-1:RV/16]         addrp,
    output logic                      mmu_miss_fault,
    output logic                      mmu_prot_fault,
    input  logic                      mmu_fault,
    input  logic                      reg_write,
    input  logic [1:0]                reg_sel,
    input  logic [RV-1:0]             reg_data,
    output logic [RV-1:0]             reg_read,
    output logic                      busy
);

    localparam int K    = $clog2(NMMU);
    localparam int C    = $clog2(NCTX);
    localparam int UNT  = VA - K;
    localparam int PW   = PA - UNT;
    localparam int LSB  = RV / 16;
    localparam int IW   = C + 2 + K;
    localparam int CW   = C + K;
    localparam int NENT = NCTX * 4 * NMMU;
    localparam int NW   = NCTX * NMMU;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    // Entry storage: V is resettable, the rest is plain RAM-like state
    logic [NENT-1:0]  r_v;
    logic [NENT-1:0]  r_ref;
    logic [NENT-1:0]  r_dirty;
    logic [PW-1:0]    r_ppage [NENT];
    // One W bit per {ctx, page}, shared by the sup and user data entries
    logic [NW-1:0]    r_w;

    // Fault register fields
    logic [K-1:0]     r_f_page;
    logic [C-1:0]     r_f_ctx;
    logic             r_f_ins;
    logic             r_f_sup;
    logic             r_f_write;
    logic             r_f_valid;

    // Flush engine
    state_t           r_state;
    logic             r_busy;
    logic             r_flush_all;
    logic [C-1:0]     r_flush_ctx;
    logic [IW-1:0]    r_cnt;

    logic [VA-1:LSB]  w_taddr;
    logic             w_sup_eff;
    logic [K-1:0]     w_vpage;
    logic [IW-1:0]    w_idx;
    logic [CW-1:0]    w_widx;
    logic             w_access;
    logic             w_flushing;
    logic             w_entry_v;
    logic [PW-1:0]    w_upper;
    logic [IW-1:0]    w_fidx;
    logic [CW-1:0]    w_fwidx;
    logic [RV-1:0]    w_freg;
    logic [RV-1:0]    w_entry;
    logic             w_reg_ok;
    logic             w_wr_freg;
    logic             w_wr_load;
    logic             w_go;
    logic [IW-1:0]    w_flush_idx;
    logic             w_flush_last;
    logic             w_unused;

    // Access decode: which address, which space, which entry
    assign w_taddr    = (is_pc && !is_write) ? pcv : addrv;
    assign w_sup_eff  = supmode & ~(mmu_d_proxy & ~is_pc);
    assign w_vpage    = w_taddr[VA-1:UNT];
    assign w_idx      = {ctx, is_pc, w_sup_eff, w_vpage};
    assign w_widx     = {ctx, w_vpage};
    assign w_access   = is_pc | is_read | is_write;
    assign w_flushing = r_busy & (r_flush_all | (r_flush_ctx == ctx));
    assign w_entry_v  = r_v[w_idx];

    // Combinational translation and fault detection
    assign w_upper        = mmu_enable ? r_ppage[w_idx] : PW'(w_vpage);
    assign addrp          = {w_upper, w_taddr[UNT-1:LSB]};
    assign mmu_miss_fault = mmu_enable & w_access & (~w_entry_v | w_flushing);
    assign mmu_prot_fault = mmu_enable & is_write & ~is_pc & w_entry_v & ~r_w[w_widx];

    // Entry addressed by the fault register, used by load and readback
    assign w_fidx  = {r_f_ctx, r_f_ins, r_f_sup, r_f_page};
    assign w_fwidx = {r_f_ctx, r_f_page};

    // Register write strobes; a fault commit drops any same-cycle register write
    assign w_reg_ok  = reset & ~mmu_fault & reg_write;
    assign w_wr_freg = w_reg_ok & (reg_sel == 2'd0);
    assign w_wr_load = w_reg_ok & (reg_sel == 2'd1) & ~r_busy;
    assign w_go      = w_reg_ok & (reg_sel == 2'd2) & ~r_busy & reg_data[0];

    // Flush walks either the whole table or only the target context's slice
    assign w_flush_idx  = r_flush_all ? r_cnt : {r_flush_ctx, r_cnt[K+1:0]};
    assign w_flush_last = r_flush_all ? (r_cnt == IW'(NENT - 1))
                                      : (r_cnt[K+1:0] == '1);

    assign busy = r_busy;

    // Only some reg_data bits map to register fields
    assign w_unused = ^reg_data;

    // Pack the fault register for readback
    always_comb begin
        w_freg             = '0;
        w_freg[RV-1:RV-K]  = r_f_page;
        w_freg[4+C:5]      = r_f_ctx;
        w_freg[4]          = r_f_ins;
        w_freg[3]          = r_f_sup;
        w_freg[2]          = r_f_write;
        w_freg[1]          = r_f_valid;
    end

    // Pack the selected entry for readback; ins entries have no W bit
    always_comb begin
        w_entry             = '0;
        w_entry[RV-1:RV-PW] = r_ppage[w_fidx];
        w_entry[3]          = r_dirty[w_fidx];
        w_entry[2]          = r_ref[w_fidx];
        w_entry[1]          = r_f_ins ? 1'b0 : r_w[w_fwidx];
        w_entry[0]          = r_v[w_fidx];
    end

    // Register read mux
    always_comb begin
        reg_read = '0;
        case (reg_sel)
            2'd0:    reg_read = w_freg;
            2'd3:    reg_read = w_entry;
            default: reg_read = '0;
        endcase
    end

    // Fault register: capture on fault commit, else software write
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_f_page  <= '0;
            r_f_ctx   <= '0;
            r_f_ins   <= 1'b0;
            r_f_sup   <= 1'b0;
            r_f_write <= 1'b0;
            r_f_valid <= 1'b0;
        end else if (mmu_fault) begin
            r_f_page  <= w_vpage;
            r_f_ctx   <= ctx;
            r_f_ins   <= is_pc;
            r_f_sup   <= w_sup_eff;
            r_f_write <= is_write;
            r_f_valid <= ~mmu_miss_fault;
        end else if (w_wr_freg) begin
            r_f_page  <= reg_data[RV-1:RV-K];
            r_f_ctx   <= reg_data[4+C:5];
            r_f_ins   <= reg_data[4];
            r_f_sup   <= reg_data[3];
            r_f_write <= reg_data[2];
            r_f_valid <= reg_data[1];
        end
    end

    // Flush FSM: one entry per cycle from index 0 to the last of the range
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_flush_all <= 1'b0;
            r_flush_ctx <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state     <= S_FLUSH;
                        r_busy      <= 1'b1;
                        r_flush_all <= reg_data[1];
                        r_flush_ctx <= reg_data[C+1:2];
                        r_cnt       <= '0;
                    end
                end
                S_FLUSH: begin
                    if (w_flush_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + IW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Valid bits: cleared by reset and by the flush walk, set by entry load
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v <= '0;
        end else begin
            if (w_wr_load) begin
                r_v[w_fidx] <= reg_data[0];
            end
            if (r_state == S_FLUSH) begin
                r_v[w_flush_idx] <= 1'b0;
            end
        end
    end

`ifdef MMU_DIRTY_EN
    logic w_upd_ref;
    logic w_upd_dirty;
    logic w_load_same;

    assign w_upd_ref   = reset & ~mmu_fault & mmu_enable & w_access
                       & ~mmu_miss_fault & ~mmu_prot_fault;
    assign w_upd_dirty = w_upd_ref & is_write & ~is_pc;
    assign w_load_same = w_wr_load & (w_fidx == w_idx);

    // Entry payload: software load, plus hardware R/D marking on clean accesses
    always_ff @(posedge clk) begin
        if (w_upd_ref && !w_load_same) begin
            r_ref[w_idx] <= 1'b1;
        end
        if (w_upd_dirty && !w_load_same) begin
            r_dirty[w_idx] <= 1'b1;
        end
        if (w_wr_load) begin
            r_ppage[w_fidx] <= reg_data[RV-1:RV-PW];
            r_ref[w_fidx]   <= reg_data[2];
            r_dirty[w_fidx] <= reg_data[3];
            if (!r_f_ins) begin
                r_w[w_fwidx] <= reg_data[1];
            end
        end
    end
`else
    // Entry payload: written only by software load; R/D are plain software bits
    always_ff @(posedge clk) begin
        if (w_wr_load) begin
            r_ppage[w_fidx] <= reg_data[RV-1:RV-PW];
            r_ref[w_fidx]   <= reg_data[2];
            r_dirty[w_fidx] <= reg_data[3];
            if (!r_f_ins) begin
                r_w[w_fwidx] <= reg_data[1];
            end
        end
    end
`endif

endmodule
